// File: rtl/nn_pkg.sv
// Shared definitions for the activation/argmax datapath: FSM encoding and
// the index-width helper used to size per-row class indices.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of an index into n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_unit.sv
// Combinational element activation: ReLU, or leaky ReLU where negatives are
// scaled down by an arithmetic right shift.
module relu_unit #(
    parameter int WIDTH      = 16,
    parameter int LEAKY      = 0,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    always_comb begin
        y = x;
        if (x[WIDTH-1]) begin
            if (LEAKY != 0) begin
                y = x >>> LEAK_SHIFT;
            end else begin
                y = '0;
            end
        end
    end

endmodule

// File: rtl/activation_argmax.sv
// Frame-serial activation plus per-row argmax: a captured B x M frame is
// walked one element per cycle, activated, and reduced to a class index per row.
module activation_argmax
    import nn_pkg::*;
#(
    parameter int B          = 2,
    parameter int M          = 3,
    parameter int WIDTH      = 16,
    parameter int LEAKY      = 0,
    parameter int LEAK_SHIFT = 3,
    localparam int IDXW      = idx_width(M)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data   [B][M],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] act_data  [B][M],
    output logic [IDXW-1:0]         class_idx [B],
    output logic                    busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends combinationally on ready.

    localparam int RW = idx_width(B);
    localparam logic [RW-1:0]   R_LAST = RW'(B - 1);
    localparam logic [IDXW-1:0] C_LAST = IDXW'(M - 1);

    state_t state;
    state_t state_next;

    logic                    rdy_en;
    logic                    capture;
    logic                    step;
    logic                    release_frame;
    logic                    last_elem;
    logic                    take_max;
    logic [RW-1:0]           row;
    logic [IDXW-1:0]         col;
    logic signed [WIDTH-1:0] frame_q [B][M];
    logic signed [WIDTH-1:0] elem;
    logic signed [WIDTH-1:0] elem_act;
    logic signed [WIDTH-1:0] run_max;
    logic                    out_valid_q;

    assign elem      = frame_q[row][col];
    assign last_elem = (row == R_LAST) && (col == C_LAST);
    // Strict greater-than keeps the lowest index on ties; column 0 seeds the max.
    assign take_max  = (col == '0) || (elem_act > run_max);
    assign out_valid = out_valid_q;

    relu_unit #(
        .WIDTH      (WIDTH),
        .LEAKY      (LEAKY),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_relu (
        .x (elem),
        .y (elem_act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        busy          = 1'b0;
        capture       = 1'b0;
        step          = 1'b0;
        release_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = rdy_en;
                if (in_valid && rdy_en) begin
                    capture    = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_elem) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                if (out_valid_q && out_ready) begin
                    release_frame = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The frame buffer is only ever read after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_q <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en      <= 1'b0;
            row         <= '0;
            col         <= '0;
            run_max     <= '0;
            out_valid_q <= 1'b0;
            for (int r = 0; r < B; r++) begin
                class_idx[r] <= '0;
                for (int c = 0; c < M; c++) begin
                    act_data[r][c] <= '0;
                end
            end
        end else begin
            rdy_en <= 1'b1;
            if (capture) begin
                row <= '0;
                col <= '0;
            end
            if (step) begin
                act_data[row][col] <= elem_act;
                if (take_max) begin
                    run_max        <= elem_act;
                    class_idx[row] <= col;
                end
                if (col == C_LAST) begin
                    col <= '0;
                    row <= last_elem ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            // Results are presented one edge after the scan lands in DONE.
            if (release_frame) begin
                out_valid_q <= 1'b0;
            end else if (state == ST_DONE) begin
                out_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_activation_argmax.sv
// Directed bench for activation_argmax: one ReLU and one leaky-ReLU instance
// share stimulus; expected frames are hand-computed constants.
module tb_activation_argmax;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                out_ready;
    logic signed [15:0]  in_data [2][3];

    logic                in_ready_r, out_valid_r, busy_r;
    logic signed [15:0]  act_r [2][3];
    logic [1:0]          idx_r [2];
    logic                in_ready_l, out_valid_l, busy_l;
    logic signed [15:0]  act_l [2][3];
    logic [1:0]          idx_l [2];

    logic signed [15:0]  exp_act_r [2][3];
    logic [1:0]          exp_idx_r [2];
    logic signed [15:0]  exp_act_l [2][3];
    logic [1:0]          exp_idx_l [2];

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    always #5 clk = ~clk;

    activation_argmax #(.B(2), .M(3), .WIDTH(16), .LEAKY(0), .LEAK_SHIFT(3)) dut_relu (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready_r),
        .in_data (in_data), .out_valid (out_valid_r), .out_ready (out_ready),
        .act_data (act_r), .class_idx (idx_r), .busy (busy_r)
    );

    activation_argmax #(.B(2), .M(3), .WIDTH(16), .LEAKY(1), .LEAK_SHIFT(3)) dut_leaky (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready_l),
        .in_data (in_data), .out_valid (out_valid_l), .out_ready (out_ready),
        .act_data (act_l), .class_idx (idx_l), .busy (busy_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_ctrl(input string tag, input logic rdy, input logic vld, input logic bsy);
        check({tag, "_in_ready_relu"},  32'(in_ready_r),  32'(rdy));
        check({tag, "_in_ready_leaky"}, 32'(in_ready_l),  32'(rdy));
        check({tag, "_out_valid_relu"}, 32'(out_valid_r), 32'(vld));
        check({tag, "_out_valid_leaky"},32'(out_valid_l), 32'(vld));
        check({tag, "_busy_relu"},      32'(busy_r),      32'(bsy));
        check({tag, "_busy_leaky"},     32'(busy_l),      32'(bsy));
    endtask

    task automatic check_outputs(input string tag);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("%s_relu_act_%0d_%0d", tag, r, c), 32'(act_r[r][c]), 32'(exp_act_r[r][c]));
                check($sformatf("%s_leaky_act_%0d_%0d", tag, r, c), 32'(act_l[r][c]), 32'(exp_act_l[r][c]));
            end
            check($sformatf("%s_relu_idx_%0d", tag, r), 32'(idx_r[r]), 32'(exp_idx_r[r]));
            check($sformatf("%s_leaky_idx_%0d", tag, r), 32'(idx_l[r]), 32'(exp_idx_l[r]));
        end
    endtask

    task automatic set_frame(input logic [15:0] a0, a1, a2, b0, b1, b2);
        in_data[0][0] = a0; in_data[0][1] = a1; in_data[0][2] = a2;
        in_data[1][0] = b0; in_data[1][1] = b1; in_data[1][2] = b2;
    endtask

    task automatic set_frame_a();
        set_frame(16'h0100, 16'hFF00, 16'h0200, 16'hFE00, 16'hFF80, 16'hFF00);
    endtask

    task automatic set_frame_b();
        set_frame(16'h8000, 16'h8000, 16'h7FFF, 16'h0005, 16'h0005, 16'h0001);
    endtask

    task automatic set_exp_zero();
        for (int r = 0; r < 2; r++) begin
            exp_idx_r[r] = 2'd0;
            exp_idx_l[r] = 2'd0;
            for (int c = 0; c < 3; c++) begin
                exp_act_r[r][c] = 16'h0000;
                exp_act_l[r][c] = 16'h0000;
            end
        end
    endtask

    task automatic set_exp_a();
        exp_act_r[0][0] = 16'h0100; exp_act_r[0][1] = 16'h0000; exp_act_r[0][2] = 16'h0200;
        exp_act_r[1][0] = 16'h0000; exp_act_r[1][1] = 16'h0000; exp_act_r[1][2] = 16'h0000;
        exp_idx_r[0] = 2'd2; exp_idx_r[1] = 2'd0;
        exp_act_l[0][0] = 16'h0100; exp_act_l[0][1] = 16'hFFE0; exp_act_l[0][2] = 16'h0200;
        exp_act_l[1][0] = 16'hFFC0; exp_act_l[1][1] = 16'hFFF0; exp_act_l[1][2] = 16'hFFE0;
        exp_idx_l[0] = 2'd2; exp_idx_l[1] = 2'd1;
    endtask

    task automatic set_exp_b();
        exp_act_r[0][0] = 16'h0000; exp_act_r[0][1] = 16'h0000; exp_act_r[0][2] = 16'h7FFF;
        exp_act_r[1][0] = 16'h0005; exp_act_r[1][1] = 16'h0005; exp_act_r[1][2] = 16'h0001;
        exp_idx_r[0] = 2'd2; exp_idx_r[1] = 2'd0;
        exp_act_l[0][0] = 16'hF000; exp_act_l[0][1] = 16'hF000; exp_act_l[0][2] = 16'h7FFF;
        exp_act_l[1][0] = 16'h0005; exp_act_l[1][1] = 16'h0005; exp_act_l[1][2] = 16'h0001;
        exp_idx_l[0] = 2'd2; exp_idx_l[1] = 2'd0;
    endtask

    // Called just after the accept edge; counts edges until out_valid rises.
    task automatic wait_out_valid(input string tag);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid_r && lat < 40);
        check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_out_valid_leaky_at_latency"}, 32'(out_valid_l), 32'd1);
    endtask

    task automatic run_frame(input string tag);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_ctrl({tag, "_scan"}, 1'b0, 1'b0, 1'b1);
        wait_out_valid(tag);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_ctrl({tag, "_after_handshake"}, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_frame(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        set_exp_zero();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_ctrl("post_reset", 1'b1, 1'b0, 1'b0);

        // Mixed-sign frame on both activations
        set_frame_a();
        run_frame("frame_a");
        set_exp_a();
        check_outputs("frame_a");
        handshake("frame_a");

        // Most-negative / most-positive values and a tie
        set_frame_b();
        run_frame("frame_b");
        set_exp_b();
        check_outputs("frame_b");
        handshake("frame_b");

        // Back-pressure in DONE with new data offered
        set_frame_a();
        run_frame("hold");
        set_exp_a();
        set_frame_b();
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            check_ctrl($sformatf("hold_cyc%0d", i), 1'b0, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        check_outputs("hold");
        handshake("hold");

        // Reset in the third scan cycle discards the frame
        set_frame_a();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        set_exp_zero();
        check_ctrl("mid_reset", 1'b0, 1'b0, 1'b0);
        check_outputs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_ctrl("mid_reset_release", 1'b1, 1'b0, 1'b0);
        set_frame_b();
        run_frame("after_reset");
        set_exp_b();
        check_outputs("after_reset");
        handshake("after_reset");

        // Back-to-back frames with in_valid and out_ready held high
        set_frame_a();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_ctrl("b2b_first_scan", 1'b0, 1'b0, 1'b1);
        wait_out_valid("b2b_first");
        set_frame_b();
        @(posedge clk); #1;
        set_exp_a();
        check_ctrl("b2b_handshake", 1'b1, 1'b0, 1'b0);
        check_outputs("b2b_first_retained");
        @(posedge clk); #1;
        check_ctrl("b2b_second_accept", 1'b0, 1'b0, 1'b1);
        wait_out_valid("b2b_second");
        in_valid = 1'b0;
        set_exp_b();
        check_outputs("b2b_second");
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_ctrl("b2b_end", 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
